sobel_edge: RTL and testbench

Sobel edge-detection stage placed directly downstream of the video filter stage in the DVP video-processing chain. It consumes the filter's 24-bit RGB pixel stream with its vs/de framing, converts each pixel to 8-bit luma, and builds a 3×3 window from two internal line buffers. It computes |Gx|+|Gy| and emits a binary edge map as 24-bit pixels, with framing and fixed latency matched to the input.

---
 rtl/sobel_edge.sv | 210 +++++++++++++++++++++
 tb/tb_sobel_edge.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge.sv
// -----------------------------------------------------------------------------
// sobel_edge
// Sobel edge-detection stage for the DVP video chain. Converts each incoming
// RGB pixel to 8-bit luma, builds a 3x3 window from two line buffers, computes
// |Gx|+|Gy| and emits an edge map with framing delayed by a fixed 5 cycles.
//
// Optional feature macro: SOBEL_GRAY_OUT_EN
//   defined   -> post_data = {M,M,M}, M = saturated G (threshold ignored)
//   undefined -> post_data = 24'hFFFFFF when G > threshold, else 24'h000000
//
// Ports:
//   clk        pixel clock
//   rst_n      asynchronous active-low reset
//   threshold  edge threshold, used by the final stage every cycle
//   per_vs     input frame sync (rising edge starts a frame)
//   per_de     input data enable
//   per_data   input pixel {R,G,B}
//   post_vs    per_vs delayed 5 cycles
//   post_de    per_de delayed 5 cycles
//   post_data  edge pixel, zero whenever post_de is low
// -----------------------------------------------------------------------------
module sobel_edge #(
    parameter logic [11:0] IMG_HDISP = 12'd1280,
    parameter logic [11:0] IMG_VDISP = 12'd720
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  threshold,
    input  logic        per_vs,
    input  logic        per_de,
    input  logic [23:0] per_data,
    output logic        post_vs,
    output logic        post_de,
    output logic [23:0] post_data
);

    localparam int LB_AW = (IMG_HDISP > 12'd1) ? $clog2(IMG_HDISP) : 1;

    // Absolute value of an 11-bit two's-complement gradient.
    function automatic logic [10:0] abs11(input logic signed [10:0] v);
        return v[10] ? (~v + 11'd1) : v;
    endfunction

    // Input-side counters
    logic [11:0]            x_cnt_r;
    logic [11:0]            row_cnt_r;
    // Stage 1: luma
    logic [7:0]             y_s1_r;
    logic                   de_s1_r;
    logic                   vs_s1_r;
    logic [11:0]            x_s1_r;
    logic [11:0]            row_s1_r;
    // Line buffers (not reset)
    logic [7:0]             buf_a_r [0:int'(IMG_HDISP)-1];
    logic [7:0]             buf_b_r [0:int'(IMG_HDISP)-1];
    // Stage 2: window, element [0] is the oldest column
    logic [2:0][7:0]        win_top_r;
    logic [2:0][7:0]        win_mid_r;
    logic [2:0][7:0]        win_bot_r;
    logic                   de_s2_r;
    logic                   vs_s2_r;
    logic                   border_s2_r;
    // Stage 3: gradients
    logic signed [10:0]     gx_s3_r;
    logic signed [10:0]     gy_s3_r;
    logic                   de_s3_r;
    logic                   vs_s3_r;
    logic                   border_s3_r;
    // Stage 4: magnitude
    logic [10:0]            g_s4_r;
    logic                   de_s4_r;
    logic                   vs_s4_r;
    logic                   border_s4_r;

    // Combinational helpers
    logic [15:0]            luma_sum_s;
    logic                   de_fall_s;
    logic                   vs_rise_s;
    logic [LB_AW-1:0]       lb_addr_s;
    logic [7:0]             lb_a_rd_s;
    logic [7:0]             lb_b_rd_s;
    logic [10:0]            gx_pos_s;
    logic [10:0]            gx_neg_s;
    logic [10:0]            gy_pos_s;
    logic [10:0]            gy_neg_s;
    logic signed [10:0]     gx_s;
    logic signed [10:0]     gy_s;
    logic [10:0]            g_s;
    logic [7:0]             mag_s;
    logic [23:0]            pixel_s;

    // Luma, framing edge detects, line-buffer reads, gradients and decision.
    always_comb begin
        luma_sum_s = 16'd77  * {8'd0, per_data[23:16]}
                   + 16'd150 * {8'd0, per_data[15:8]}
                   + 16'd29  * {8'd0, per_data[7:0]};
        de_fall_s  = de_s1_r & ~per_de;
        vs_rise_s  = per_vs & ~vs_s1_r;
        lb_addr_s  = x_s1_r[LB_AW-1:0];
        lb_a_rd_s  = buf_a_r[lb_addr_s];
        lb_b_rd_s  = buf_b_r[lb_addr_s];
        // Gx: newest column minus oldest column, centre row weighted by 2
        gx_pos_s   = {3'd0, win_top_r[2]} + {2'd0, win_mid_r[2], 1'b0} + {3'd0, win_bot_r[2]};
        gx_neg_s   = {3'd0, win_top_r[0]} + {2'd0, win_mid_r[0], 1'b0} + {3'd0, win_bot_r[0]};
        // Gy: current row minus row r-2, centre column weighted by 2
        gy_pos_s   = {3'd0, win_bot_r[0]} + {2'd0, win_bot_r[1], 1'b0} + {3'd0, win_bot_r[2]};
        gy_neg_s   = {3'd0, win_top_r[0]} + {2'd0, win_top_r[1], 1'b0} + {3'd0, win_top_r[2]};
        gx_s       = gx_pos_s - gx_neg_s;
        gy_s       = gy_pos_s - gy_neg_s;
        g_s        = abs11(gx_s3_r) + abs11(gy_s3_r);
        mag_s      = (g_s4_r > 11'd255) ? 8'hFF : g_s4_r[7:0];
`ifdef SOBEL_GRAY_OUT_EN
        pixel_s    = {mag_s, mag_s, mag_s};
`else
        pixel_s    = (g_s4_r > {3'd0, threshold}) ? 24'hFFFFFF : 24'h000000;
`endif
    end

    // Column and row counters tracking the pixel currently at the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt_r   <= 12'd0;
            row_cnt_r <= 12'd0;
        end else begin
            if (per_de) begin
                x_cnt_r <= (x_cnt_r == IMG_HDISP - 12'd1) ? 12'd0 : x_cnt_r + 12'd1;
            end else if (de_fall_s) begin
                x_cnt_r <= 12'd0;
            end
            // A new frame wins over a simultaneous line end
            if (vs_rise_s) begin
                row_cnt_r <= 12'd0;
            end else if (de_fall_s && (row_cnt_r != IMG_VDISP - 12'd1)) begin
                row_cnt_r <= row_cnt_r + 12'd1;
            end
        end
    end

    // Line buffers: A keeps row r-1, B keeps row r-2, both rotate on de.
    always_ff @(posedge clk) begin
        if (de_s1_r) begin
            buf_a_r[lb_addr_s] <= y_s1_r;
            buf_b_r[lb_addr_s] <= lb_a_rd_s;
        end
    end

    // Stages 1 and 2: luma register, then window shift on de cycles only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_s1_r      <= 8'd0;
            de_s1_r     <= 1'b0;
            vs_s1_r     <= 1'b0;
            x_s1_r      <= 12'd0;
            row_s1_r    <= 12'd0;
            win_top_r   <= '0;
            win_mid_r   <= '0;
            win_bot_r   <= '0;
            de_s2_r     <= 1'b0;
            vs_s2_r     <= 1'b0;
            border_s2_r <= 1'b0;
        end else begin
            y_s1_r      <= luma_sum_s[15:8];
            de_s1_r     <= per_de;
            vs_s1_r     <= per_vs;
            x_s1_r      <= x_cnt_r;
            row_s1_r    <= row_cnt_r;
            if (de_s1_r) begin
                win_top_r <= {lb_b_rd_s, win_top_r[2:1]};
                win_mid_r <= {lb_a_rd_s, win_mid_r[2:1]};
                win_bot_r <= {y_s1_r,    win_bot_r[2:1]};
            end
            de_s2_r     <= de_s1_r;
            vs_s2_r     <= vs_s1_r;
            // Window is incomplete in the first two columns and rows
            border_s2_r <= (x_s1_r < 12'd2) || (row_s1_r < 12'd2);
        end
    end

    // Stages 3 to 5: gradients, magnitude, decision and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_s3_r     <= 11'sd0;
            gy_s3_r     <= 11'sd0;
            de_s3_r     <= 1'b0;
            vs_s3_r     <= 1'b0;
            border_s3_r <= 1'b0;
            g_s4_r      <= 11'd0;
            de_s4_r     <= 1'b0;
            vs_s4_r     <= 1'b0;
            border_s4_r <= 1'b0;
            post_de     <= 1'b0;
            post_vs     <= 1'b0;
            post_data   <= 24'h000000;
        end else begin
            gx_s3_r     <= gx_s;
            gy_s3_r     <= gy_s;
            de_s3_r     <= de_s2_r;
            vs_s3_r     <= vs_s2_r;
            border_s3_r <= border_s2_r;
            g_s4_r      <= g_s;
            de_s4_r     <= de_s3_r;
            vs_s4_r     <= vs_s3_r;
            border_s4_r <= border_s3_r;
            post_de     <= de_s4_r;
            post_vs     <= vs_s4_r;
            post_data   <= (de_s4_r && !border_s4_r) ? pixel_s : 24'h000000;
        end
    end

endmodule

// File: tb/tb_sobel_edge.sv
// -----------------------------------------------------------------------------
// tb_sobel_edge
// Directed bench for sobel_edge with IMG_HDISP=8, IMG_VDISP=6. Expected pixels
// come from a behavioural Sobel model over the last three input lines and are
// queued when driven; a negedge monitor pops them when post_de is seen and
// also checks post_vs/post_de against a 5-deep history of driven framing.
// -----------------------------------------------------------------------------
module tb_sobel_edge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  threshold = 8'd0;
    logic        per_vs = 1'b0;
    logic        per_de = 1'b0;
    logic [23:0] per_data = 24'h0;
    logic        post_vs;
    logic        post_de;
    logic [23:0] post_data;

    int tests_run = 0;
    int tests_failed = 0;
    int pop_cnt = 0;
    int edge_cnt = 0;

    logic [23:0] exp_q[$];
    bit          de_hist[6];
    bit          vs_hist[6];
    logic [7:0]  line_m2[8];
    logic [7:0]  line_m1[8];
    logic [7:0]  line_cur[8];
    int          row_m = 0;

    sobel_edge #(.IMG_HDISP(12'd8), .IMG_VDISP(12'd6)) dut (
        .clk(clk), .rst_n(rst_n), .threshold(threshold),
        .per_vs(per_vs), .per_de(per_de), .per_data(per_data),
        .post_vs(post_vs), .post_de(post_de), .post_data(post_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] luma(input logic [23:0] p);
        int s;
        s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
        return 8'((s % 65536) / 256);
    endfunction

    // Expected output for column x of the line being driven now.
    function automatic logic [23:0] exp_px(input int x);
        int gx, gy, g, m;
        logic [7:0] m8;
        if (row_m < 2 || x < 2) return 24'h000000;
        gx = (int'(line_m2[x]) + 2 * int'(line_m1[x]) + int'(line_cur[x]))
           - (int'(line_m2[x-2]) + 2 * int'(line_m1[x-2]) + int'(line_cur[x-2]));
        gy = (int'(line_cur[x-2]) + 2 * int'(line_cur[x-1]) + int'(line_cur[x]))
           - (int'(line_m2[x-2]) + 2 * int'(line_m2[x-1]) + int'(line_m2[x]));
        g = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_GRAY_OUT_EN
        m = (g > 255) ? 255 : g;
        m8 = 8'(m);
        return {m8, m8, m8};
`else
        m8 = 8'd0;
        return (g > int'(threshold)) ? 24'hFFFFFF : 24'h000000;
`endif
    endfunction

    // Output monitor: framing delay, scoreboard pop, zero data when idle.
    always @(negedge clk) begin
        logic [23:0] e;
        for (int i = 5; i > 0; i--) begin
            de_hist[i] = de_hist[i-1];
            vs_hist[i] = vs_hist[i-1];
        end
        de_hist[0] = per_de;
        vs_hist[0] = per_vs;
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                de_hist[i] = 1'b0;
                vs_hist[i] = 1'b0;
            end
        end
        tests_run++;
        assert (post_de === de_hist[5]) else begin
            tests_failed++;
            $error("FAIL post_de: observed %b expected %b", post_de, de_hist[5]);
        end
        tests_run++;
        assert (post_vs === vs_hist[5]) else begin
            tests_failed++;
            $error("FAIL post_vs: observed %b expected %b", post_vs, vs_hist[5]);
        end
        tests_run++;
        if (post_de === 1'b1) begin
            assert (exp_q.size() > 0) else begin
                tests_failed++;
                $error("FAIL sb_underflow: observed empty queue expected an entry");
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                pop_cnt++;
                if (post_data === 24'hFFFFFF) edge_cnt++;
                tests_run++;
                assert (post_data === e) else begin
                    tests_failed++;
                    $error("FAIL pixel: observed %h expected %h", post_data, e);
                end
            end
        end else begin
            assert (post_data === 24'h000000) else begin
                tests_failed++;
                $error("FAIL idle_data: observed %h expected 000000", post_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        per_de = 1'b0;
        per_vs = 1'b0;
        per_data = 24'h0;
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic vs_pulse();
        per_vs = 1'b1;
        tick();
        per_vs = 1'b0;
        row_m = 0;
        idle(3);
    endtask

    // One line: columns 0-3 = left, 4-7 = right.
    task automatic send_line(input logic [23:0] left, input logic [23:0] right);
        for (int x = 0; x < 8; x++) begin
            per_de = 1'b1;
            per_data = (x < 4) ? left : right;
            line_cur[x] = luma(per_data);
            exp_q.push_back(exp_px(x));
            tick();
        end
        per_de = 1'b0;
        per_data = 24'h0;
        line_m2 = line_m1;
        line_m1 = line_cur;
        row_m = (row_m == 5) ? 5 : row_m + 1;
        idle(3);
    endtask

    task automatic run_frame(input string tag, input logic [23:0] left, input logic [23:0] right,
                             input logic [7:0] th, input int exp_edges);
        threshold = th;
        pop_cnt = 0;
        edge_cnt = 0;
        vs_pulse();
        repeat (6) send_line(left, right);
        idle(8);
        check({tag, "_pulses"}, pop_cnt, 48);
        check({tag, "_edges"}, edge_cnt, exp_edges);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            line_m2[i] = 8'd0;
            line_m1[i] = 8'd0;
            line_cur[i] = 8'd0;
        end
        // Reset held while inputs toggle
        for (int i = 0; i < 8; i++) begin
            per_de = 1'b1;
            per_vs = (i % 2 == 1);
            per_data = 24'($urandom);
            tick();
            check("rst_vs", {31'd0, post_vs}, 0);
            check("rst_de", {31'd0, post_de}, 0);
            check("rst_data", {8'd0, post_data}, 0);
        end
        idle(1);
        rst_n = 1'b1;
        row_m = 0;
        idle(10);
        check("post_rst_vs", {31'd0, post_vs}, 0);
        check("post_rst_de", {31'd0, post_de}, 0);
        check("post_rst_data", {8'd0, post_data}, 0);

        run_frame("uniform", 24'h808080, 24'h808080, 8'd20, 0);
        run_frame("vedge", 24'h000000, 24'hFFFFFF, 8'd100, 8);
`ifdef SOBEL_GRAY_OUT_EN
        run_frame("step_t40", 24'h000000, 24'h0A0A0A, 8'd40, 0);
        run_frame("step_t39", 24'h000000, 24'h0A0A0A, 8'd39, 0);
`else
        run_frame("step_t40", 24'h000000, 24'h0A0A0A, 8'd40, 0);
        run_frame("step_t39", 24'h000000, 24'h0A0A0A, 8'd39, 8);
`endif

        // Frame restart after input row 3
        threshold = 8'd100;
        pop_cnt = 0;
        edge_cnt = 0;
        vs_pulse();
        repeat (4) send_line(24'h000000, 24'hFFFFFF);
        vs_pulse();
        repeat (6) send_line(24'h000000, 24'hFFFFFF);
        idle(8);
        check("restart_pulses", pop_cnt, 80);
        check("restart_edges", edge_cnt, 12);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
